// File: rtl/imm_pkg.sv
// Immediate format codes shared by the immediate extender and the immediate encoder.
// Also carries the reference extender so both directions agree on field placement.
package imm_pkg;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_J = 3'b011,
      IMM_U = 3'b100
   } imm_src_e;

   localparam int unsigned XLEN = 32;

   function automatic logic [XLEN-1:0] imm_extend(input logic [2:0] src,
                                                  input logic [XLEN-1:0] instr);
      logic [XLEN-1:0] ext;
      ext = '0;
      case (src)
         IMM_I: ext = {{20{instr[31]}}, instr[31:20]};
         IMM_S: ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B: ext = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_J: ext = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         IMM_U: ext = {instr[31:12], 12'h000};
         default: ext = '0;
      endcase
      return ext;
   endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational immediate packer: scatters imm into the format's instruction fields
// over base_instr and flags immediates the format cannot represent.
module imm_pack (
   input  logic [2:0]  imm_src,
   input  logic [31:0] imm,
   input  logic [31:0] base_instr,
   output logic [31:0] instr,
   output logic        err
);
   import imm_pkg::*;

   // A value fits an N-bit signed field when every bit from N-1 upward matches the sign.
   logic fit12;
   logic fit13;
   logic fit21;

   assign fit12 = (imm[31:11] == '0) || (imm[31:11] == '1);
   assign fit13 = (imm[31:12] == '0) || (imm[31:12] == '1);
   assign fit21 = (imm[31:20] == '0) || (imm[31:20] == '1);

   always_comb begin
      instr = base_instr;
      err   = 1'b0;
      case (imm_src)
         IMM_I: begin
            instr[31:20] = imm[11:0];
            err          = !fit12;
         end
         IMM_S: begin
            instr[31:25] = imm[11:5];
            instr[11:7]  = imm[4:0];
            err          = !fit12;
         end
         IMM_B: begin
            instr[31]    = imm[12];
            instr[7]     = imm[11];
            instr[30:25] = imm[10:5];
            instr[11:8]  = imm[4:1];
            err          = imm[0] || !fit13;
         end
         IMM_J: begin
            instr[31]    = imm[20];
            instr[19:12] = imm[19:12];
            instr[20]    = imm[11];
            instr[30:21] = imm[10:1];
            err          = imm[0] || !fit21;
         end
         IMM_U: begin
            instr[31:12] = imm[31:12];
            err          = (imm[11:0] != '0);
         end
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready pipeline around imm_pack: S1 registers the encoded result,
// S2 presents it downstream; also counts delivered error transfers (saturating).
module imm_encoder (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  imm_src,
   input  logic [31:0] imm,
   input  logic [31:0] base_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic        out_err,
   output logic [7:0]  err_count
);
   import imm_pkg::*;

   logic [31:0] pack_instr;
   logic        pack_err;
   logic        s1_valid;
   logic [31:0] s1_instr;
   logic        s1_err;
   logic        s2_adv;
   logic        s1_adv;

   imm_pack u_pack (
      .imm_src    (imm_src),
      .imm        (imm),
      .base_instr (base_instr),
      .instr      (pack_instr),
      .err        (pack_err)
   );

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_instr  <= '0;
         s1_err    <= 1'b0;
         out_valid <= 1'b0;
         out_instr <= '0;
         out_err   <= 1'b0;
         err_count <= '0;
      end else begin
         if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_instr <= pack_instr;
               s1_err   <= pack_err;
            end
         end
         // Data registers only load on a real transfer so a stalled output holds.
         if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_instr <= s1_instr;
               out_err   <= s1_err;
            end
         end
         if (out_valid && out_ready && out_err && (err_count != '1))
            err_count <= err_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: expectations queued at drive time, checked on delivery.
module tb_imm_encoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  imm_src = '0;
   logic [31:0] imm = '0;
   logic [31:0] base_instr = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_instr;
   logic        out_err;
   logic [7:0]  err_count;

   typedef struct {
      logic [2:0]  src;
      logic [31:0] imm;
      logic [31:0] exp_instr;
      logic        exp_err;
   } txn_t;

   txn_t q[$];
   int   total = 0;
   int   bad = 0;
   int   delivered = 0;

   imm_encoder dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .imm_src    (imm_src),
      .imm        (imm),
      .base_instr (base_instr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_instr  (out_instr),
      .out_err    (out_err),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   // Reference encoder built on integer ranges, independent of the RTL's bit tests.
   function automatic void model(input logic [2:0] s, input logic [31:0] v,
                                 input logic [31:0] b, output logic [31:0] r,
                                 output logic e);
      int sv;
      sv = $signed(v);
      r = b;
      e = 1'b0;
      case (s)
         3'd0: begin r[31:20] = v[11:0]; e = (sv < -2048) || (sv > 2047); end
         3'd1: begin r[31:25] = v[11:5]; r[11:7] = v[4:0]; e = (sv < -2048) || (sv > 2047); end
         3'd2: begin
            r[31] = v[12]; r[7] = v[11]; r[30:25] = v[10:5]; r[11:8] = v[4:1];
            e = v[0] || (sv < -4096) || (sv > 4094);
         end
         3'd3: begin
            r[31] = v[20]; r[19:12] = v[19:12]; r[20] = v[11]; r[30:21] = v[10:1];
            e = v[0] || (sv < -1048576) || (sv > 1048574);
         end
         3'd4: begin r[31:12] = v[31:12]; e = (v[11:0] != 12'h000); end
         default: e = 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] ext_model(input logic [2:0] s, input logic [31:0] i);
      case (s)
         3'd0: return {{20{i[31]}}, i[31:20]};
         3'd1: return {{20{i[31]}}, i[31:25], i[11:7]};
         3'd2: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         3'd3: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         3'd4: return {i[31:12], 12'h000};
         default: return 32'h0;
      endcase
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      q.delete();
      rst = 1'b0;
   endtask

   task automatic drive_exp(input logic [2:0] s, input logic [31:0] v, input logic [31:0] b,
                            input logic [31:0] ei, input logic ee);
      txn_t t;
      bit   acc;
      int   n;
      imm_src = s;
      imm = v;
      base_instr = b;
      in_valid = 1'b1;
      t.src = s;
      t.imm = v;
      t.exp_instr = ei;
      t.exp_err = ee;
      q.push_back(t);
      acc = 1'b0;
      n = 0;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      if (!acc) begin
         total++; bad++;
         $display("FAIL accept_timeout src=%0d imm=%h never accepted", s, v);
      end
   endtask

   task automatic drive(input logic [2:0] s, input logic [31:0] v, input logic [31:0] b);
      logic [31:0] ei;
      logic        ee;
      model(s, v, b, ei, ee);
      drive_exp(s, v, b, ei, ee);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((q.size() != 0 || out_valid) && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      if (q.size() != 0 || out_valid) begin
         total++; bad++;
         $display("FAIL drain_timeout pending=%0d out_valid=%0b want 0", q.size(), out_valid);
      end
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
      total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err got %0b want 0", out_err); end
      total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_out_instr got %h want 0", out_instr); end
      total++; if (err_count !== 8'd0) begin bad++; $display("FAIL reset_err_count got %0d want 0", err_count); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
   endtask

   task automatic test_vectors();
      do_reset();
      drive_exp(3'd0, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_early got out_valid=%0b want 0", out_valid); end
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL latency_two got out_valid=%0b want 1", out_valid); end
      wait_drain();
      drive_exp(3'd2, 32'h0000_0800, 32'h0000_0063, 32'h0000_00E3, 1'b0);
      drive_exp(3'd2, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 1'b1);
      wait_drain();
      total++; if (err_count !== 8'd1) begin bad++; $display("FAIL err_count_b got %0d want 1", err_count); end
      drive_exp(3'd3, 32'h000F_FFFE, 32'h0000_006F, 32'h7FFF_F06F, 1'b0);
      drive_exp(3'd4, 32'h1234_5001, 32'h0000_0037, 32'h1234_5037, 1'b1);
      drive_exp(3'd1, 32'h0000_07FF, 32'h0000_0023, 32'h7E00_0FA3, 1'b0);
      drive_exp(3'd6, 32'h0000_0004, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
      // Range boundaries for each format
      drive(3'd0, 32'd2047, 32'h0000_0013);
      drive(3'd0, -32'sd2048, 32'h0000_0013);
      drive(3'd0, 32'd2048, 32'h0000_0013);
      drive(3'd1, -32'sd2049, 32'h0000_0023);
      drive(3'd2, 32'd4094, 32'h0000_0063);
      drive(3'd2, -32'sd4096, 32'h0000_0063);
      drive(3'd2, 32'd4096, 32'h0000_0063);
      drive(3'd3, 32'd1048574, 32'h0000_006F);
      drive(3'd3, -32'sd1048576, 32'h0000_006F);
      drive(3'd3, 32'd1048576, 32'h0000_006F);
      drive(3'd4, 32'hFFFF_F000, 32'h0000_0037);
      wait_drain();
      total++; if (err_count !== 8'd7) begin bad++; $display("FAIL err_count_vec got %0d want 7", err_count); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] held_i;
      logic        held_e;
      bit          have;
      int          start;
      do_reset();
      start = delivered;
      have = 1'b0;
      fork
         begin
            for (int i = 0; i < 8; i++)
               drive(3'(i % 5), 32'(i * 68) - 32'd200, 32'h0100_0000 * 32'(i) + 32'h13);
         end
         begin
            for (int c = 0; c < 20; c++) begin
               out_ready = !(c >= 3 && c <= 5);
               @(negedge clk);
               if (out_valid && !out_ready) begin
                  if (have) begin
                     total++;
                     if (out_instr !== held_i || out_err !== held_e) begin
                        bad++;
                        $display("FAIL stall_stable got %h/%0b want %h/%0b", out_instr, out_err, held_i, held_e);
                     end
                  end
                  held_i = out_instr;
                  held_e = out_err;
                  have = 1'b1;
               end else begin
                  have = 1'b0;
               end
               @(posedge clk); #1;
            end
            out_ready = 1'b1;
         end
      join
      wait_drain();
      total++;
      if (delivered - start !== 8) begin
         bad++;
         $display("FAIL b2b_count got %0d want 8", delivered - start);
      end
   endtask

   task automatic test_random();
      bit          done;
      logic [31:0] r;
      logic [31:0] v;
      logic [2:0]  s;
      do_reset();
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 10000; i++) begin
               r = $urandom;
               case ($urandom_range(0, 4))
                  0: v = r;
                  1: v = {{20{r[11]}}, r[11:0]};
                  2: v = {{19{r[12]}}, r[12:1], 1'b0};
                  3: v = {{11{r[20]}}, r[20:1], 1'b0};
                  default: v = {r[31:12], 12'h000};
               endcase
               s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
               drive(s, v, $urandom);
               if ($urandom_range(0, 7) == 0) begin
                  @(posedge clk); #1;
               end
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               out_ready = ($urandom_range(0, 3) != 0);
               @(posedge clk); #1;
            end
            out_ready = 1'b1;
         end
      join
      wait_drain();
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 200; i++) drive(3'd7, 32'(i), 32'h0000_0013);
      wait_drain();
      total++; if (err_count !== 8'd200) begin bad++; $display("FAIL err_count_200 got %0d want 200", err_count); end
      for (int i = 0; i < 100; i++) drive(3'd4, 32'h0000_0001, 32'h0000_0037);
      wait_drain();
      total++; if (err_count !== 8'd255) begin bad++; $display("FAIL err_count_sat got %0d want 255", err_count); end
   endtask

   task automatic test_reset_flight();
      bit stale;
      do_reset();
      out_ready = 1'b0;
      drive(3'd0, 32'd5, 32'h0000_0013);
      drive(3'd0, 32'd6, 32'h0000_0013);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flight_loaded got out_valid=%0b want 1", out_valid); end
      rst = 1'b1;
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flight_reset got out_valid=%0b want 0", out_valid); end
      rst = 1'b0;
      q.delete();
      out_ready = 1'b1;
      stale = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (out_valid) stale = 1'b1;
      end
      total++; if (stale !== 1'b0) begin bad++; $display("FAIL flight_stale got out_valid=1 want 0"); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flight_in_ready got %0b want 1", in_ready); end
   endtask

   initial begin
      fork
         forever begin
            txn_t t;
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
               delivered++;
               total++;
               if (q.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_output got instr=%h want none", out_instr);
               end else begin
                  t = q.pop_front();
                  if (out_instr !== t.exp_instr || out_err !== t.exp_err) begin
                     bad++;
                     $display("FAIL encode src=%0d imm=%h got %h/%0b want %h/%0b",
                              t.src, t.imm, out_instr, out_err, t.exp_instr, t.exp_err);
                  end
                  if (out_err === 1'b0) begin
                     total++;
                     if (ext_model(t.src, out_instr) !== t.imm) begin
                        bad++;
                        $display("FAIL roundtrip src=%0d got %h want %h",
                                 t.src, ext_model(t.src, out_instr), t.imm);
                     end
                  end
               end
            end
         end
      join_none
      test_reset();
      test_vectors();
      test_back_to_back();
      test_random();
      test_saturation();
      test_reset_flight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have ports: in_valid  in  1  request valid; in_ready  out  1  request accepted when high with in_valid.
REQ-003 SHALL have ports: imm_src  in  3  format code (I=000, S=001, B=010, J=011, U=100); imm  in  32  signed/raw immediate value; base_instr  in  32  instruction supplying all non-immediate bits.
REQ-004 SHALL have ports: out_valid  out  1; out_ready  in  1; out_instr  out  32  packed instruction; out_err  out  1  immediate not representable.
REQ-005 SHALL have port err_count  out  8  saturating count of transfers delivered with out_err=1.
REQ-006 Clocking SHALL be one clock, clk; reset SHALL be rst, synchronous and active-high.

Function
REQ-007 SHALL be the inverse of the immediate extender: for every error-free result, extending out_instr with the same imm_src SHALL return imm exactly.
REQ-008 I: out_instr[31:20]=imm[11:0]; err if imm outside -2048..2047.
REQ-009 S: [31:25]=imm[11:5], [11:7]=imm[4:0]; err if imm outside -2048..2047.
REQ-010 B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]; err if imm[0]=1 or imm outside -4096..4094.
REQ-011 J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1]; err if imm[0]=1 or imm outside -1048576..1048574.
REQ-012 U: [31:12]=imm[31:12]; err if imm[11:0] != 0.
REQ-013 All bits not named for the format SHALL equal base_instr; immediate bits SHALL be filled from the truncated imm even when err=1.
REQ-014 imm_src 101..111: out_instr=base_instr, out_err=1.
REQ-015 Pipeline: two register stages (S1 capture+encode, S2 output); latency 2 cycles from accept to out_valid with no stall; throughput 1/cycle.
REQ-016 Handshake: S2 advances when !out_valid or out_ready; S1 advances when S1 empty or S2 advances; in_ready = S1 can advance (combinational from out_ready allowed).
REQ-017 While out_valid=1 and out_ready=0, out_instr/out_err SHALL hold stable; no transfer lost or duplicated.
REQ-018 err_count SHALL increment in the cycle out_valid&out_ready&out_err, saturating at 255.
REQ-019 Simultaneous accept and deliver SHALL both occur in the same cycle.

Reset
REQ-020 rst SHALL clear both stage valids; out_valid=0, out_err=0, out_instr=0, err_count=0; in_ready=1 the cycle after reset.
REQ-021 rst mid-operation SHALL discard all in-flight requests; none emerge after reset.

Structure
REQ-022 Format codes I/S/B/J/U SHALL live in shared package imm_pkg, used by both the extender and this block.
REQ-023 Field packing and range checks SHALL be in combinational sub-module imm_pack (imm_src, imm, base_instr -> instr, err); imm_encoder holds pipeline, handshake, counter.

Verification
REQ-024 I, imm=-1, base=0x00000013 -> out_instr=0xFFF00013, err=0, out_valid 2 cycles after accept.
REQ-025 B, imm=0x00000800, base=0x00000063 -> out_instr=0x000000E3, err=0; imm=3 -> err=1, err_count=1.
REQ-026 J, imm=0x000FFFFE, base=0x0000006F -> out_instr=0x7FFFF06F, err=0; U, imm=0x12345001 -> err=1.
REQ-027 Stream 8 back-to-back requests, out_ready low cycles 3-5 -> all 8 delivered in order, no duplication, outputs stable during stall.
REQ-028 Random 10k imm/imm_src through imm_pack then extender -> equals imm whenever err=0; 300 err transfers -> err_count=255.
REQ-029 rst asserted with 2 requests in flight -> out_valid=0 next cycle, no stale output afterwards.
